// File: rtl/opensocdebug_pkg.sv
// Shared types for the mor1kx control-flow trace event queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package opensocdebug_pkg;

  // Widths of the shared structures. The queue's parameters must not exceed these.
  localparam int TRACE_ADDR_WIDTH = 32;
  localparam int EVT_ADDR_WIDTH   = 32;
  localparam int EVT_TIME_WIDTH   = 32;
  localparam int EVT_CNT_WIDTH    = 16;

  // mor1kx major opcodes (insn[31:26]) that matter for control flow
  localparam logic [5:0] OP_J    = 6'h00;
  localparam logic [5:0] OP_JAL  = 6'h01;
  localparam logic [5:0] OP_BNF  = 6'h03;
  localparam logic [5:0] OP_BF   = 6'h04;
  localparam logic [5:0] OP_JR   = 6'h11;
  localparam logic [5:0] OP_JALR = 6'h12;

  // l.jr through the link register is treated as a function return
  localparam logic [4:0] LINK_REG = 5'd9;

  typedef enum logic [2:0] {
    EV_SEQ          = 3'd0,
    EV_JUMP         = 3'd1,
    EV_JUMP_REG     = 3'd2,
    EV_RETURN       = 3'd3,
    EV_BRANCH_TAKEN = 3'd4,
    EV_DISCONT      = 3'd5
  } ctm_event_kind_e;

  // Retired-instruction record from the mor1kx execution trace port
  typedef struct packed {
    logic                        valid;
    logic [TRACE_ADDR_WIDTH-1:0] pc;
    logic [TRACE_ADDR_WIDTH-1:0] npc;
    logic [31:0]                 insn;
  } mor1kx_trace_exec;

  // One queued trace event; 'tstamp' is the capture cycle's timestamp
  typedef struct packed {
    logic [EVT_ADDR_WIDTH-1:0] pc;
    logic [EVT_ADDR_WIDTH-1:0] npc;
    ctm_event_kind_e           kind;
    logic [EVT_TIME_WIDTH-1:0] tstamp;
    logic [EVT_CNT_WIDTH-1:0]  lost;
  } ctm_event_t;

endpackage

// File: rtl/osd_ctm_evq_fifo.sv
// Generic synchronous show-ahead FIFO with full/empty flags.
// Latency: a write is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: writes into a full FIFO are ignored unless a pop happens in the same cycle.
module osd_ctm_evq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  // Extra pointer MSB distinguishes full from empty when the indices coincide
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = rd_rdy && !empty;
  assign push   = wr_vld && (!full || pop);
  assign rd_vld = !empty;
  // Head data reads as zero while empty so idle outputs stay quiet
  assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards every queued entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/osd_ctm_mor1kx_evq.sv
// Classifies retired mor1kx instructions, filters by mode, timestamps and queues them.
// Latency: qualified trace in cycle t is at the queue head in cycle t+2; one event per cycle.
// Backpressure: out_valid/out_ready; events arriving at a full queue are dropped and counted.
module osd_ctm_mor1kx_evq
  import opensocdebug_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TIME_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  mor1kx_trace_exec      trace_port,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_npc,
  output logic [2:0]            out_kind,
  output logic [TIME_WIDTH-1:0] out_time,
  output logic [CNT_WIDTH-1:0]  out_lost,
  output logic                  status_overflow
);

  logic [ADDR_WIDTH-1:0] tp_pc;
  logic [ADDR_WIDTH-1:0] tp_npc;
  logic [5:0]            op;
  logic [4:0]            rb;
  logic                  discont;
  ctm_event_kind_e       kind;
  logic                  mode_pass;
  logic                  qual;
  logic                  unused_insn_bits;

  logic [TIME_WIDTH-1:0] ts_q;
  logic                  s1_vld;
  logic [ADDR_WIDTH-1:0] s1_pc;
  logic [ADDR_WIDTH-1:0] s1_npc;
  ctm_event_kind_e       s1_kind;
  logic [TIME_WIDTH-1:0] s1_time;

  logic [CNT_WIDTH-1:0]  lost_q;
  logic                  en_q;
  logic                  ovf_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  ctm_event_t            wr_ev;
  ctm_event_t            head;

  assign tp_pc   = trace_port.pc[ADDR_WIDTH-1:0];
  assign tp_npc  = trace_port.npc[ADDR_WIDTH-1:0];
  assign op      = trace_port.insn[31:26];
  assign rb      = trace_port.insn[15:11];
  assign discont = (tp_npc != tp_pc + ADDR_WIDTH'(4));

  // Instruction bits that never influence classification
  assign unused_insn_bits = ^{trace_port.insn[25:16], trace_port.insn[10:0]};

  // Classify the retired instruction, most specific kind first
  always_comb begin
    kind = EV_SEQ;
    if (op == OP_JR && rb == LINK_REG)                kind = EV_RETURN;
    else if (op == OP_JR || op == OP_JALR)            kind = EV_JUMP_REG;
    else if (op == OP_J || op == OP_JAL)              kind = EV_JUMP;
    else if ((op == OP_BNF || op == OP_BF) && discont) kind = EV_BRANCH_TAKEN;
    else if (discont)                                 kind = EV_DISCONT;
  end

  // Mode filter; the reserved mode falls back to control transfers only
  always_comb begin
    mode_pass = 1'b0;
    case (cfg_mode)
      2'd0:    mode_pass = 1'b1;
      2'd2:    mode_pass = (kind inside {EV_JUMP, EV_JUMP_REG, EV_RETURN});
      default: mode_pass = (kind != EV_SEQ);
    endcase
  end

  assign qual = trace_port.valid && cfg_enable && mode_pass;

  // Free-running timestamp, independent of capture enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TIME_WIDTH'(1);
  end

  // Capture stage: register the qualified event with this cycle's timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_pc   <= '0;
      s1_npc  <= '0;
      s1_kind <= EV_SEQ;
      s1_time <= '0;
    end else begin
      s1_vld <= qual;
      if (qual) begin
        s1_pc   <= tp_pc;
        s1_npc  <= tp_npc;
        s1_kind <= kind;
        s1_time <= ts_q;
      end
    end
  end

  // A full queue still accepts the write when its head leaves in the same cycle
  assign pop     = out_valid && out_ready;
  assign push_ok = s1_vld && (!fifo_full || pop);
  assign drop    = s1_vld && !push_ok;

  // Queue entry carries the number of events lost just before it
  always_comb begin
    wr_ev        = '0;
    wr_ev.pc     = EVT_ADDR_WIDTH'(s1_pc);
    wr_ev.npc    = EVT_ADDR_WIDTH'(s1_npc);
    wr_ev.kind   = s1_kind;
    wr_ev.tstamp = EVT_TIME_WIDTH'(s1_time);
    wr_ev.lost   = EVT_CNT_WIDTH'(lost_q);
  end

  // Lost-event counter: saturating on drops, handed off and cleared on the next write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_q <= '0;
    end else if (push_ok) begin
      lost_q <= '0;
    end else if (drop && lost_q != {CNT_WIDTH{1'b1}}) begin
      lost_q <= lost_q + CNT_WIDTH'(1);
    end
  end

  // Sticky overflow flag; a fresh drop wins over a same-cycle enable rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      en_q <= cfg_enable;
      if (drop)                     ovf_q <= 1'b1;
      else if (cfg_enable && !en_q) ovf_q <= 1'b0;
    end
  end

  osd_ctm_evq_fifo #(
    .WIDTH ($bits(ctm_event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (s1_vld),
    .wr_dat (wr_ev),
    .rd_rdy (out_ready),
    .rd_vld (out_valid),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_pc          = head.pc[ADDR_WIDTH-1:0];
  assign out_npc         = head.npc[ADDR_WIDTH-1:0];
  assign out_kind        = head.kind;
  assign out_time        = head.tstamp[TIME_WIDTH-1:0];
  assign out_lost        = head.lost[CNT_WIDTH-1:0];
  assign status_overflow = ovf_q || (fifo_empty && 1'b0);

endmodule

// File: tb/tb_osd_ctm_mor1kx_evq.sv
// Self-checking bench for the mor1kx trace event queue against an event-level reference model.
// Latency: one stimulus step per clock; outputs observed on the falling edge.
// Backpressure: out_ready is driven per step, directed and randomized.
module tb_osd_ctm_mor1kx_evq;
  import opensocdebug_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  mor1kx_trace_exec trace_port;
  logic             cfg_enable;
  logic [1:0]       cfg_mode;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_npc;
  logic [2:0]       out_kind;
  logic [31:0]      out_time;
  logic [15:0]      out_lost;
  logic             status_overflow;

  always #5 clk = ~clk;

  osd_ctm_mor1kx_evq #(
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .TIME_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trace_port      (trace_port),
    .cfg_enable      (cfg_enable),
    .cfg_mode        (cfg_mode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_npc         (out_npc),
    .out_kind        (out_kind),
    .out_time        (out_time),
    .out_lost        (out_lost),
    .status_overflow (status_overflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    int          kind;
    logic [31:0] t;
    int          lost;
  } ev_t;

  // Reference state: queued events, the one event in flight, loss bookkeeping
  ev_t   mq[$];
  bit    inflight;
  ev_t   inflight_ev;
  int    mlost;
  bit    movf;
  bit    prev_en;
  int    cyc;

  int    checks;
  int    errors;
  int    first_vld_cyc;
  int    n_pop;
  int    popped_lost[$];
  bit    stall_prev;
  logic [31:0] prev_pc, prev_npc, prev_time;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_kind(input logic [31:0] insn, input logic [31:0] pc,
                                  input logic [31:0] npc);
    int op;
    bit away;
    op   = int'(insn[31:26]);
    away = (npc != pc + 32'd4);
    if (op == 'h11 && insn[15:11] == 5'd9) return 3;
    if (op == 'h11 || op == 'h12) return 2;
    if (op == 'h00 || op == 'h01) return 1;
    if ((op == 'h03 || op == 'h04) && away) return 4;
    if (away) return 5;
    return 0;
  endfunction

  function automatic bit ref_pass(input int mode, input int kind);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (kind >= 1 && kind <= 3);
    return (kind != 0);
  endfunction

  // One clock cycle: drive, observe at the falling edge, then advance the model
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] npc,
                      input logic [31:0] insn, input bit rdy);
    ev_t h;
    ev_t e;
    bit  drop;
    int  k;
    trace_port = '{valid: v, pc: pc, npc: npc, insn: insn};
    out_ready  = rdy;
    @(negedge clk);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      h = mq[0];
      chk("out_pc", out_pc, h.pc);
      chk("out_npc", out_npc, h.npc);
      chk("out_kind", out_kind, h.kind);
      chk("out_time", out_time, h.t);
      chk("out_lost", out_lost, h.lost);
    end
    chk("status_overflow", status_overflow, movf);
    if (stall_prev && out_valid) begin
      chk("stall_pc", out_pc, prev_pc);
      chk("stall_npc", out_npc, prev_npc);
      chk("stall_time", out_time, prev_time);
    end
    stall_prev = out_valid && !rdy;
    prev_pc = out_pc; prev_npc = out_npc; prev_time = out_time;
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (out_valid && rdy) begin
      n_pop++;
      popped_lost.push_back(int'(out_lost));
    end
    // Reference update for the clock edge ending this cycle
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    drop = 1'b0;
    if (inflight) begin
      if (mq.size() < DEPTH) begin
        e = inflight_ev;
        e.lost = mlost;
        mq.push_back(e);
        mlost = 0;
      end else begin
        drop = 1'b1;
        if (mlost < 65535) mlost++;
        movf = 1'b1;
      end
    end
    if (!drop && cfg_enable && !prev_en) movf = 1'b0;
    prev_en  = cfg_enable;
    k        = ref_kind(insn, pc, npc);
    inflight = v && cfg_enable && ref_pass(int'(cfg_mode), k);
    inflight_ev = '{pc: pc, npc: npc, kind: k, t: cyc, lost: 0};
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_npc", out_npc, 0);
    chk("rst_out_kind", out_kind, 0);
    chk("rst_out_time", out_time, 0);
    chk("rst_out_lost", out_lost, 0);
    chk("rst_overflow", status_overflow, 0);
    chk("rst_timestamp", dut.ts_q, 0);
    trace_port = '0;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    inflight = 1'b0;
    mlost = 0; movf = 1'b0; prev_en = 1'b0; cyc = 0;
    stall_prev = 1'b0; first_vld_cyc = -1;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [5:0] ops [8];
    logic [31:0] w;
    ops = '{6'h00, 6'h01, 6'h03, 6'h04, 6'h11, 6'h12, 6'h05, 6'h21};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 1) == 1) w[15:11] = 5'd9;
    return w;
  endfunction

  task automatic rand_step(input bit v, input bit rdy);
    logic [31:0] pc;
    logic [31:0] npc;
    pc  = {$urandom, 2'b00} ;
    npc = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : {$urandom, 2'b00};
    step(v, pc, npc, rand_insn(), rdy);
  endtask

  int base;

  initial begin
    checks = 0; errors = 0; n_pop = 0;
    trace_port = '0; out_ready = 1'b0; cfg_enable = 1'b1; cfg_mode = 2'd0;
    do_reset();

    // First event: l.jal in cycle 5 appears in cycle 7
    idle(5, 1'b1);
    step(1'b1, 32'h100, 32'h140, 32'h04000010, 1'b1);
    idle(4, 1'b1);
    chk("first_latency_cycle", first_vld_cyc, 7);

    // Kind coverage, then the same sequence under jump-only mode
    for (int m = 0; m < 3; m += 2) begin
      cfg_mode = 2'(m);
      base = n_pop;
      step(1'b1, 32'h400, 32'h1000, 32'h44004800, 1'b1);
      step(1'b1, 32'h404, 32'h2000, 32'h44001800, 1'b1);
      step(1'b1, 32'h200, 32'h180, 32'h10000000, 1'b1);
      step(1'b1, 32'h200, 32'h204, 32'h10000000, 1'b1);
      idle(4, 1'b1);
      chk("mode_event_count", n_pop - base, (m == 0) ? 4 : 2);
    end

    // Control-transfer mode: sequential code is silent, an exception is not
    cfg_mode = 2'd1;
    base = n_pop;
    for (int i = 0; i < 100; i++)
      step(1'b1, 32'h1000 + 32'(i * 4), 32'h1004 + 32'(i * 4), 32'h15000000, 1'b1);
    step(1'b1, 32'h300, 32'h800, 32'h15000000, 1'b1);
    idle(4, 1'b1);
    chk("mode1_event_count", n_pop - base, 1);

    // Overflow: 11 jumps into a stalled 8-entry queue
    cfg_mode = 2'd0;
    for (int i = 0; i < 11; i++)
      step(1'b1, 32'h2000 + 32'(i * 16), 32'h3000, 32'h00000010, 1'b0);
    idle(2, 1'b0);
    chk("overflow_set", status_overflow, 1);
    popped_lost.delete();
    step(1'b1, 32'h5000, 32'h5100, 32'h00000010, 1'b1);
    idle(12, 1'b1);
    chk("ninth_pop_lost", (popped_lost.size() > 8) ? popped_lost[8] : -1, 3);
    chk("overflow_sticky", status_overflow, 1);
    cfg_enable = 1'b0;
    idle(1, 1'b1);
    cfg_enable = 1'b1;
    idle(2, 1'b1);
    chk("overflow_cleared", status_overflow, 0);

    // Back-to-back events with out_ready toggling every cycle
    for (int i = 0; i < 60; i++) rand_step(1'b1, i[0]);
    idle(20, 1'b1);

    // Randomized operation with mode/enable changes and random backpressure
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) cfg_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) cfg_enable = ~cfg_enable;
      rand_step($urandom_range(0, 4) != 0, $urandom_range(0, 9) < 6);
    end
    cfg_enable = 1'b1;
    idle(20, 1'b1);

    // Reset with events queued; nothing stale may appear afterwards
    cfg_mode = 2'd0;
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h6000 + 32'(i * 8), 32'h7000, 32'h00000010, 1'b0);
    idle(2, 1'b0);
    chk("queued_before_reset", out_valid, 1);
    do_reset();
    base = n_pop;
    idle(10, 1'b1);
    chk("no_stale_events", n_pop - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
